// File: rtl/matrix_pkg.sv
// Shared constants and types for the matrix streaming blocks.
// Holds the default element format, transmitter state encoding and index-width helper.
package matrix_pkg;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_FRAC_WIDTH = 8;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_STREAM,
    TX_DRAIN
  } tx_state_t;

  // Index width that stays legal when a dimension is 1.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/stream_skid_buffer.sv
// Output register plus 1-entry skid for a tagged element stream; 1 cycle in-to-out.
// Downstream stall holds out_* steady; a return arriving while stalled parks in the skid.
module stream_skid_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int ROW_W      = 1,
  parameter int COL_W      = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [ROW_W-1:0]      in_row,
  input  logic [COL_W-1:0]      in_col,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ROW_W-1:0]      out_row,
  output logic [COL_W-1:0]      out_col,
  input  logic                  out_stall,
  output logic                  skid_valid
);
  logic [DATA_WIDTH-1:0] skid_data;
  logic [ROW_W-1:0]      skid_row;
  logic [COL_W-1:0]      skid_col;
  logic                  out_free;

  assign out_free = !out_valid || !out_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_row    <= '0;
      out_col    <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_row   <= '0;
      skid_col   <= '0;
    end else if (out_free) begin
      if (skid_valid) begin
        // Skid drains first so ordering is preserved.
        out_valid  <= 1'b1;
        out_data   <= skid_data;
        out_row    <= skid_row;
        out_col    <= skid_col;
        skid_valid <= in_valid;
        skid_data  <= in_data;
        skid_row   <= in_row;
        skid_col   <= in_col;
      end else begin
        out_valid <= in_valid;
        if (in_valid) begin
          out_data <= in_data;
          out_row  <= in_row;
          out_col  <= in_col;
        end
      end
    end else if (in_valid) begin
      skid_valid <= 1'b1;
      skid_data  <= in_data;
      skid_row   <= in_row;
      skid_col   <= in_col;
    end
  end
endmodule

// File: rtl/matrix_stream_tx.sv
// Streams a ROWS x COLS buffer as tagged elements in row- or column-major order.
// First element 3 cycles after start; stall blocks new reads, skid absorbs the one in flight.
module matrix_stream_tx
  import matrix_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ROWS       = 64,
  parameter int COLS       = 64,
  parameter int ADDR_WIDTH = idx_w(ROWS * COLS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     col_major,
  output logic                     mem_en,
  output logic [ADDR_WIDTH-1:0]    mem_addr,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic [idx_w(ROWS)-1:0]   out_row,
  output logic [idx_w(COLS)-1:0]   out_col,
  output logic                     out_valid,
  input  logic                     out_stall,
  output logic                     busy,
  output logic                     done
);
  localparam int ROW_W = idx_w(ROWS);
  localparam int COL_W = idx_w(COLS);

  tx_state_t        state;
  logic             order_cm;
  logic [ROW_W-1:0] r, rd_row;
  logic [COL_W-1:0] c, rd_col;
  logic             rd_inflight;
  logic             skid_valid;
  logic             r_last, c_last;

  assign r_last   = (r == ROW_W'(ROWS - 1));
  assign c_last   = (c == COL_W'(COLS - 1));
  assign mem_en   = (state == TX_STREAM) && !out_stall && !skid_valid;
  assign mem_addr = ADDR_WIDTH'(r) * ADDR_WIDTH'(COLS) + ADDR_WIDTH'(c);
  assign busy     = (state != TX_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= TX_IDLE;
      order_cm    <= 1'b0;
      r           <= '0;
      c           <= '0;
      rd_inflight <= 1'b0;
      rd_row      <= '0;
      rd_col      <= '0;
      done        <= 1'b0;
    end else begin
      done        <= 1'b0;
      rd_inflight <= mem_en;
      rd_row      <= r;
      rd_col      <= c;
      case (state)
        TX_IDLE: begin
          if (start) begin
            order_cm <= col_major;
            r        <= '0;
            c        <= '0;
            state    <= TX_STREAM;
          end
        end
        TX_STREAM: begin
          if (mem_en) begin
            if (r_last && c_last) begin
              r     <= '0;
              c     <= '0;
              state <= TX_DRAIN;
            end else if (!order_cm) begin
              if (c_last) begin
                c <= '0;
                r <= r + ROW_W'(1);
              end else begin
                c <= c + COL_W'(1);
              end
            end else begin
              if (r_last) begin
                r <= '0;
                c <= c + COL_W'(1);
              end else begin
                r <= r + ROW_W'(1);
              end
            end
          end
        end
        TX_DRAIN: begin
          // Finish once the last element leaves this cycle and nothing is behind it.
          if (!rd_inflight && !skid_valid && (!out_valid || !out_stall)) begin
            done  <= 1'b1;
            state <= TX_IDLE;
          end
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

  stream_skid_buffer #(
    .DATA_WIDTH(DATA_WIDTH),
    .ROW_W     (ROW_W),
    .COL_W     (COL_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rd_inflight),
    .in_data   (mem_rdata),
    .in_row    (rd_row),
    .in_col    (rd_col),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_row   (out_row),
    .out_col   (out_col),
    .out_stall (out_stall),
    .skid_valid(skid_valid)
  );
endmodule

// File: tb/tb_matrix_stream_tx.sv
// Directed bench for matrix_stream_tx on a 2x3 buffer holding 1..6.
module tb_matrix_stream_tx;
  logic        clk, rst, start, col_major, mem_en, out_valid, out_stall, busy, done;
  logic [2:0]  mem_addr;
  logic [15:0] mem_rdata, out_data;
  logic [0:0]  out_row;
  logic [1:0]  out_col;
  logic [15:0] mem [6];

  int n_chk = 0;
  int n_fail = 0;

  typedef struct { int cyc; int row; int col; int dat; } elem_t;
  typedef struct {
    logic        cm;
    logic [31:0] stall_mask;
    logic [31:0] start_mask;
    int          done_cyc;
    int          el;
  } scen_t;

  elem_t exp_el [3][6];
  scen_t sc [4];

  matrix_stream_tx #(.DATA_WIDTH(16), .ROWS(2), .COLS(3)) dut (
    .clk(clk), .rst(rst), .start(start), .col_major(col_major),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .out_data(out_data), .out_row(out_row), .out_col(out_col),
    .out_valid(out_valid), .out_stall(out_stall), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (mem_en) mem_rdata <= mem[mem_addr];

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic run_xfer(input int s);
    int n = 0, n_en = 0, n_en_stall = 0, bad_busy = 0, done_k = -1;
    int a_cyc[8], a_row[8], a_col[8], a_dat[8];
    bit held = 0;
    int h_row = 0, h_col = 0, h_dat = 0;
    @(posedge clk); #1;
    start = 1'b1; col_major = sc[s].cm; out_stall = sc[s].stall_mask[0];
    for (int k = 1; k <= 60 && done_k < 0; k++) begin
      @(posedge clk); #1;
      start = sc[s].start_mask[k];
      col_major = !sc[s].cm;
      out_stall = sc[s].stall_mask[k];
      @(negedge clk);
      if (held && out_valid) begin
        check($sformatf("s%0d hold row c%0d", s, k), int'(out_row), h_row);
        check($sformatf("s%0d hold col c%0d", s, k), int'(out_col), h_col);
        check($sformatf("s%0d hold dat c%0d", s, k), int'(out_data), h_dat);
      end
      held = out_valid && out_stall;
      h_row = int'(out_row); h_col = int'(out_col); h_dat = int'(out_data);
      if (mem_en) n_en++;
      if (mem_en && out_stall) n_en_stall++;
      if (busy !== (k < sc[s].done_cyc)) bad_busy++;
      if (out_valid && !out_stall && n < 8) begin
        a_cyc[n] = k; a_row[n] = int'(out_row); a_col[n] = int'(out_col); a_dat[n] = int'(out_data);
        n++;
      end
      if (done) done_k = k;
    end
    if (done_k < 0) check($sformatf("s%0d done timeout", s), 0, 1);
    check($sformatf("s%0d done cycle", s), done_k, sc[s].done_cyc);
    check($sformatf("s%0d element count", s), n, 6);
    check($sformatf("s%0d mem_en count", s), n_en, 6);
    check($sformatf("s%0d mem_en while stalled", s), n_en_stall, 0);
    check($sformatf("s%0d busy violations", s), bad_busy, 0);
    for (int i = 0; i < 6 && i < n; i++) begin
      check($sformatf("s%0d e%0d cycle", s, i), a_cyc[i], exp_el[sc[s].el][i].cyc);
      check($sformatf("s%0d e%0d row", s, i), a_row[i], exp_el[sc[s].el][i].row);
      check($sformatf("s%0d e%0d col", s, i), a_col[i], exp_el[sc[s].el][i].col);
      check($sformatf("s%0d e%0d data", s, i), a_dat[i], exp_el[sc[s].el][i].dat);
    end
  endtask

  task automatic idle_check(input string name, input int cycles);
    int act = 0;
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk); #1;
      start = 1'b0; out_stall = 1'b0;
      @(negedge clk);
      if (busy || done || out_valid || mem_en) act++;
    end
    check(name, act, 0);
  endtask

  initial begin
    for (int i = 0; i < 6; i++) mem[i] = 16'(i + 1);
    exp_el[0][0] = '{3, 0, 0, 1}; exp_el[0][1] = '{4, 0, 1, 2}; exp_el[0][2] = '{5, 0, 2, 3};
    exp_el[0][3] = '{6, 1, 0, 4}; exp_el[0][4] = '{7, 1, 1, 5}; exp_el[0][5] = '{8, 1, 2, 6};
    exp_el[1][0] = '{3, 0, 0, 1}; exp_el[1][1] = '{4, 1, 0, 4}; exp_el[1][2] = '{5, 0, 1, 2};
    exp_el[1][3] = '{6, 1, 1, 5}; exp_el[1][4] = '{7, 0, 2, 3}; exp_el[1][5] = '{8, 1, 2, 6};
    exp_el[2][0] = '{3, 0, 0, 1};  exp_el[2][1] = '{8, 0, 1, 2};  exp_el[2][2] = '{9, 0, 2, 3};
    exp_el[2][3] = '{11, 1, 0, 4}; exp_el[2][4] = '{12, 1, 1, 5}; exp_el[2][5] = '{13, 1, 2, 6};
    sc[0] = '{1'b0, 32'h0,          32'h0,   9,  0};
    sc[1] = '{1'b1, 32'h0,          32'h0,   9,  1};
    sc[2] = '{1'b0, 32'b1111_0000,  32'h0,   14, 2};
    sc[3] = '{1'b0, 32'h0,          32'hA4,  9,  0};

    rst = 1'b1; start = 1'b0; col_major = 1'b0; out_stall = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset mem_en", int'(mem_en), 0);
    check("reset mem_addr", int'(mem_addr), 0);
    check("reset out_valid", int'(out_valid), 0);
    check("reset out_data", int'(out_data), 0);
    check("reset out_row/col", int'({out_row, out_col}), 0);
    check("reset busy/done", int'({busy, done}), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_xfer(0);
    run_xfer(1);
    run_xfer(2);
    run_xfer(3);
    idle_check("idle after restart pulses", 4);

    // Abort mid-transfer with reset held for cycle 5.
    @(posedge clk); #1;
    start = 1'b1; col_major = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("pre-abort out_valid", int'(out_valid), 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort mem_en", int'(mem_en), 0);
    check("abort mem_addr", int'(mem_addr), 0);
    check("abort out_valid", int'(out_valid), 0);
    check("abort out_data", int'(out_data), 0);
    check("abort out_row/col", int'({out_row, out_col}), 0);
    check("abort busy/done", int'({busy, done}), 0);
    idle_check("no activity after abort", 12);

    run_xfer(0);
    run_xfer(0);
    idle_check("idle at end", 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/matrix_stream_tx.md
Name: matrix_stream_tx

Overview:
- Transmitter feeding the tagged element-load interface of the matrix engines (data + row + col + valid).
- Reads a ROWS x COLS matrix from a row-major single-port buffer with 1-cycle read latency.
- Emits every element exactly once with its true coordinates, in row-major or column-major order.
- Honours a downstream stall and pulses done after the last element is accepted.

Parameters:
- DATA_WIDTH, 16, element width (signed fixed point, passed through unmodified)
- ROWS, 64, matrix rows (>=1)
- COLS, 64, matrix columns (>=1)
- ADDR_WIDTH, $clog2(ROWS*COLS), buffer address width

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin transfer; sampled only in IDLE
- col_major  in  1  traversal order, latched at start: 0 = row-major, 1 = column-major
- mem_en  out  1  buffer read enable
- mem_addr  out  ADDR_WIDTH  read address, r*COLS+c
- mem_rdata  in  DATA_WIDTH  read data, valid the cycle after mem_en
- out_data  out  DATA_WIDTH  element value
- out_row  out  $clog2(ROWS)  element row tag
- out_col  out  $clog2(COLS)  element column tag
- out_valid  out  1  element present
- out_stall  in  1  downstream hold; an element transfers when out_valid && !out_stall
- busy  out  1  high in STREAM and DRAIN
- done  out  1  one-cycle pulse at end of transfer

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE. All outputs are 0: mem_en, mem_addr, out_*, busy, done. Counters, skid and in-flight tag cleared. Any pending read is discarded. Reset mid-transfer aborts with no done pulse.
- States:
  - IDLE: start=1 -> latch col_major, clear r/c counters -> STREAM.
  - STREAM: issue reads. After the last issue -> DRAIN.
  - DRAIN: no issue. When the output register and skid are both empty -> pulse done -> IDLE.
- start is ignored while busy.
- Issue rule: mem_en = (state==STREAM) && !out_stall && !skid_valid. mem_addr and tags are taken from the current counters; counters advance only on issue.
- Counter order:
  - Row-major: c increments; wrap at COLS-1 to 0 with r+1.
  - Column-major: r increments; wrap at ROWS-1 to 0 with c+1.
  - The last issue is at (ROWS-1, COLS-1) in both orders.
- Read return: tags of the issued read are delayed one cycle alongside mem_rdata.
  - If the output register is empty or being consumed this cycle, the returning element loads into out_*.
  - Otherwise it loads into a 1-entry skid register.
  - When the output is consumed and the skid is full, the skid moves to out_* in that cycle, with priority over nothing (no issue can be returning while the skid is full).
- Capacity: at most one read in flight. Output register plus skid cannot overflow under any out_stall pattern.
- Output stability: out_data, out_row and out_col are held constant while out_valid && out_stall.
- Latency, no stall: start sampled at cycle 0.
  - First mem_en at cycle 1; first out_valid at cycle 3.
  - Elements on consecutive cycles 3..ROWS*COLS+2.
  - done=1 at cycle ROWS*COLS+3; busy=0 from that cycle.
- busy: asserted from the cycle after start through the cycle before done.
- start in the same cycle as done (IDLE re-entry): accepted on the next cycle only, since done coincides with the IDLE entry edge.
- ROWS=1 or COLS=1: same rules; wrap logic degenerates correctly.
- No arithmetic on data: out_data is bit-identical to the buffer contents.

Decomposition:
- Shared package matrix_pkg:
  - DATA_WIDTH and FRAC_WIDTH defaults.
  - tx state encoding (IDLE, STREAM, DRAIN).
  - Index-width helper constants.
- Sub-module stream_skid_buffer: 1-entry skid holding {data,row,col} with valid/stall handshake. Output register plus skid, reusable by future streamers.
- The counter/FSM stays in matrix_stream_tx.

Test Plan:
- ROWS=2, COLS=3, buffer[i]=i+1, col_major=0, out_stall=0 -> out_valid cycles 3..8 emitting (0,0,1),(0,1,2),(0,2,3),(1,0,4),(1,1,5),(1,2,6); done at cycle 9 only.
- Same buffer, col_major=1 -> order (0,0,1),(1,0,4),(0,1,2),(1,1,5),(0,2,3),(1,2,6); done after 6th element.
- out_stall=1 for cycles 4..7 during row-major run -> element 2 held stable, no mem_en while stalled with skid full, no loss or duplicate; all 6 delivered in order; done one cycle after the last acceptance.
- start re-pulsed during STREAM -> ignored: exactly 6 elements, one done.
- rst asserted at cycle 5 mid-transfer -> next cycle all outputs 0, state IDLE, no done; a new start streams all 6 from (0,0).
- Back-to-back: start asserted in the cycle after done -> second full transfer with identical sequence and timing.
